tile_map_writer: RTL and testbench

//  Rebuilds the 20x15 tile map in the display BRAM once per frame from live car/player positions.

---
 rtl/tile_map_writer.sv | 218 +++++++++++++++++++++
 tb/tb_tile_map_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_writer.sv
// Rebuilds the 20x15 tile map in display BRAM once per frame from a snapshot of
// car/player positions, and flags player/car overlap at the end of each sweep.
module tile_map_writer #(
  parameter int          GRID_W        = 20,
  parameter int          GRID_H        = 15,
  parameter int          NUM_CARS      = 10,
  parameter logic [14:0] ROAD_ROW_MASK = 15'b001111101111100
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_frame_start,
  input  logic [4:0]            i_player_x,
  input  logic [3:0]            i_player_y,
  input  logic [NUM_CARS*5-1:0] i_car_x,
  input  logic [NUM_CARS*4-1:0] i_car_y,
  output logic                  o_wr_en,
  output logic [10:0]           o_wr_addr,
  output logic [15:0]           o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_collision,
  output logic                  o_overrun
);

  localparam logic [3:0] TILE_CAR    = 4'd0;
  localparam logic [3:0] TILE_GRASS  = 4'd1;
  localparam logic [3:0] TILE_PLAYER = 4'd2;
  localparam logic [3:0] TILE_ROAD   = 4'd6;

  localparam logic [4:0] GRID_W_L  = 5'(GRID_W);
  localparam logic [3:0] GRID_H_L  = 4'(GRID_H);
  localparam logic [3:0] LAST_ROW  = 4'(GRID_H - 1);
  localparam logic [2:0] LAST_WORD = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_WRITE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Position snapshot: the sweep only ever looks at these, never the live inputs.
  logic [4:0]            px_q, px_d;
  logic [3:0]            py_q, py_d;
  logic [NUM_CARS*5-1:0] cx_q, cx_d;
  logic [NUM_CARS*4-1:0] cy_q, cy_d;

  logic [3:0]  row_q, row_d;
  logic [2:0]  word_q, word_d;
  logic        hit_q, hit_d;

  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        collision_q, collision_d;
  logic        overrun_q, overrun_d;

  // Four tiles of one BRAM word; leftmost column lands in the top nibble.
  function automatic logic [15:0] pack_word(
    input logic [3:0]            row,
    input logic [2:0]            word,
    input logic [4:0]            px,
    input logic [3:0]            py,
    input logic [NUM_CARS*5-1:0] cx,
    input logic [NUM_CARS*4-1:0] cy
  );
    logic [15:0] data;
    logic [4:0]  col;
    logic [3:0]  tile;
    logic        car_here;
    data = '0;
    for (int t = 0; t < 4; t++) begin
      col      = {word, 2'b00} + 5'(t);
      car_here = 1'b0;
      for (int k = 0; k < NUM_CARS; k++) begin
        if (cx[5*k +: 5] == col && cy[4*k +: 4] == row) car_here = 1'b1;
      end
      tile = ROAD_ROW_MASK[row] ? TILE_ROAD : TILE_GRASS;
      // Off-grid sprites can never equal an on-grid column, so they vanish here.
      if (car_here && col < GRID_W_L)                 tile = TILE_CAR;
      if (px == col && py == row && col < GRID_W_L)   tile = TILE_PLAYER;
      data[15-4*t -: 4] = tile;
    end
    return data;
  endfunction

  function automatic logic collides(
    input logic [4:0]            px,
    input logic [3:0]            py,
    input logic [NUM_CARS*5-1:0] cx,
    input logic [NUM_CARS*4-1:0] cy
  );
    logic any_car;
    any_car = 1'b0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (cx[5*k +: 5] == px && cy[4*k +: 4] == py) any_car = 1'b1;
    end
    return any_car && (px < GRID_W_L) && (py < GRID_H_L);
  endfunction

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    row_d       = row_q;
    word_d      = word_q;
    hit_d       = hit_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    collision_d = 1'b0;
    overrun_d   = i_frame_start && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          px_d    = i_player_x;
          py_d    = i_player_y;
          cx_d    = i_car_x;
          cy_d    = i_car_y;
          state_d = S_SNAP;
        end
      end
      S_SNAP: begin
        row_d   = '0;
        word_d  = '0;
        hit_d   = collides(px_q, py_q, cx_q, cy_q);
        busy_d  = 1'b1;
        wr_en_d = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // row_q/word_q name the word on the port this cycle; the next one is
        // registered now so writes stay back-to-back.
        if (row_q == LAST_ROW && word_q == LAST_WORD) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          collision_d = hit_q;
          state_d     = S_DONE;
        end else begin
          if (word_q == LAST_WORD) begin
            word_d = '0;
            row_d  = row_q + 4'd1;
          end else begin
            word_d = word_q + 3'd1;
          end
          wr_en_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en_d) begin
      wr_addr_d = {3'b000, row_d, 1'b0, word_d};
      wr_data_d = pack_word(row_d, word_d, px_q, py_q, cx_q, cy_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      row_q       <= '0;
      word_q      <= '0;
      hit_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      row_q       <= row_d;
      word_q      <= word_d;
      hit_q       <= hit_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_collision = collision_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Self-checking bench for tile_map_writer: directed cases plus randomized sweeps
// compared against a cell-by-cell tile model of the frame.
module tb_tile_map_writer;

  localparam int NC = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [4:0]        player_x;
  logic [3:0]        player_y;
  logic [NC*5-1:0]   car_x;
  logic [NC*4-1:0]   car_y;
  logic              wr_en;
  logic [10:0]       wr_addr;
  logic [15:0]       wr_data;
  logic              busy, done, collision, overrun;

  int tests = 0;
  int fails = 0;

  int m_px, m_py;
  int m_cx [NC];
  int m_cy [NC];
  logic [15:0] last_got [75];

  tile_map_writer dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_player_x    (player_x),
    .i_player_y    (player_y),
    .i_car_x       (car_x),
    .i_car_y       (car_y),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_busy        (busy),
    .o_done        (done),
    .o_collision   (collision),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tile at a map cell straight from the game rules.
  function automatic int model_tile(int r, int c);
    int tile;
    tile = ((r >= 2 && r <= 6) || (r >= 8 && r <= 12)) ? 6 : 1;
    for (int k = 0; k < NC; k++)
      if (m_cx[k] == c && m_cy[k] == r) tile = 0;
    if (m_px == c && m_py == r) tile = 2;
    return tile;
  endfunction

  function automatic logic [15:0] model_word(int r, int w);
    logic [15:0] d;
    d = '0;
    for (int j = 0; j < 4; j++) d = (d << 4) | 16'(model_tile(r, 4*w + j));
    return d;
  endfunction

  function automatic int model_coll();
    if (m_px >= 20 || m_py >= 15) return 0;
    for (int k = 0; k < NC; k++)
      if (m_cx[k] == m_px && m_cy[k] == m_py) return 1;
    return 0;
  endfunction

  task automatic drive_positions();
    player_x = 5'(m_px);
    player_y = 4'(m_py);
    for (int k = 0; k < NC; k++) begin
      car_x[5*k +: 5] = 5'(m_cx[k]);
      car_y[4*k +: 4] = 4'(m_cy[k]);
    end
  endtask

  task automatic clear_cars();
    for (int k = 0; k < NC; k++) begin
      m_cx[k] = 31;
      m_cy[k] = 0;
    end
  endtask

  // One frame: pulse at relative cycle 0, observe 90 cycles after it.
  task automatic run_sweep(input string name, input int ovr_at, input bit scramble, input int rst_at);
    int first_wr = -1, last_wr = -1, done_at = -1, n_done = 0, n_wr = 0;
    int coll = 0, ovr_seen = -1, post_rst_wr = 0, bad_addr = 0, not_once = 0;
    int cnt [75];
    int r, w;
    for (int i = 0; i < 75; i++) cnt[i] = 0;
    @(negedge clk);
    drive_positions();
    frame_start = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = i;
        last_wr = i;
        if (rst_at > 0 && i > rst_at + 2) post_rst_wr++;
        r = int'(wr_addr) >> 4;
        w = int'(wr_addr) & 15;
        if (r < 15 && w < 5) begin
          cnt[r*5 + w]++;
          last_got[r*5 + w] = wr_data;
        end else begin
          bad_addr++;
        end
      end
      if (done) begin
        n_done++;
        done_at = i;
        coll = int'(collision);
      end
      if (overrun) ovr_seen = i;
      @(negedge clk);
      frame_start = (ovr_at > 0 && i == ovr_at);
      if (scramble && i < 80) begin
        player_x = 5'($urandom_range(0, 31));
        player_y = 4'($urandom_range(0, 15));
        car_x    = {$urandom, $urandom};
        car_y    = {$urandom, $urandom};
      end
      if (rst_at > 0 && i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({name, " rst_wr_en"}, 32'(wr_en), 0);
        check({name, " rst_busy"}, 32'(busy), 0);
      end
      if (rst_at > 0 && i == rst_at + 2) rst_n = 1'b1;
    end
    if (rst_at > 0) begin
      check({name, " writes_after_rst"}, post_rst_wr, 0);
      check({name, " done_after_rst"}, n_done, 0);
      return;
    end
    for (int i = 0; i < 75; i++) if (cnt[i] != 1) not_once++;
    check({name, " write_count"}, n_wr, 75);
    check({name, " bad_addr"}, bad_addr, 0);
    check({name, " each_word_once"}, not_once, 0);
    check({name, " first_write"}, first_wr, 2);
    check({name, " last_write"}, last_wr, 76);
    check({name, " done_cycle"}, done_at, 77);
    check({name, " done_pulses"}, n_done, 1);
    check({name, " collision"}, coll, model_coll());
    check({name, " overrun"}, ovr_seen, (ovr_at > 0) ? ovr_at + 1 : -1);
    for (int rr = 0; rr < 15; rr++)
      for (int ww = 0; ww < 5; ww++)
        if (cnt[rr*5 + ww] == 1)
          check($sformatf("%s r%0d w%0d", name, rr, ww), 32'(last_got[rr*5 + ww]), 32'(model_word(rr, ww)));
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    m_px = 0; m_py = 0;
    clear_cars();
    drive_positions();
    #22;
    check("reset wr_en", 32'(wr_en), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset outputs", {16'(wr_data), 5'(wr_addr), 1'(collision), 1'(overrun)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Empty grid with the player on the bottom row.
    clear_cars();
    m_px = 10; m_py = 14;
    run_sweep("empty", 0, 1'b0, 0);
    check("empty row0", 32'(last_got[0]), 32'h1111);
    check("empty row2", 32'(last_got[10]), 32'h6666);
    check("empty player_word", 32'(last_got[72]), 32'h1121);

    // Player sitting on car 0: player tile wins, collision flagged.
    clear_cars();
    m_cx[0] = 3; m_cy[0] = 2;
    m_px = 3; m_py = 2;
    run_sweep("overlap", 0, 1'b0, 0);
    check("overlap word", 32'(last_got[10]), 32'h6662);

    // Two cars in one word of road row 5.
    clear_cars();
    m_cx[0] = 4; m_cy[0] = 5;
    m_cx[1] = 7; m_cy[1] = 5;
    m_px = 0; m_py = 0;
    run_sweep("two_cars", 0, 1'b0, 0);
    check("two_cars addr81", 32'(last_got[26]), 32'h0660);
    check("two_cars w0", 32'(last_got[25]), 32'h6666);
    check("two_cars w2", 32'(last_got[27]), 32'h6666);

    // Off-grid player and car at the same coordinates never collide.
    clear_cars();
    m_cx[2] = 25; m_cy[2] = 3;
    m_px = 25; m_py = 3;
    run_sweep("offgrid", 0, 1'b0, 0);

    // Stacked cars in one cell plus a car in the last column.
    clear_cars();
    m_cx[3] = 19; m_cy[3] = 14;
    m_cx[4] = 8;  m_cy[4] = 9;
    m_cx[5] = 8;  m_cy[5] = 9;
    m_px = 19; m_py = 0;
    run_sweep("edges", 0, 1'b0, 0);

    // Second frame pulse mid-sweep.
    run_sweep("overrun", 30, 1'b0, 0);

    // Inputs changing every cycle after the snapshot.
    clear_cars();
    m_cx[0] = 6; m_cy[0] = 7;
    m_cx[1] = 12; m_cy[1] = 3;
    m_px = 6; m_py = 7;
    run_sweep("scramble", 0, 1'b1, 0);

    // Reset in the middle of the sweep, then a clean frame afterwards.
    run_sweep("midreset", 0, 1'b0, 40);
    run_sweep("after_rst", 0, 1'b0, 0);

    // Random frames, half of them with a car forced onto the player.
    for (int s = 0; s < 6; s++) begin
      m_px = $urandom_range(0, 19);
      m_py = $urandom_range(0, 14);
      for (int k = 0; k < NC; k++) begin
        m_cx[k] = ($urandom_range(0, 4) == 0) ? 31 : $urandom_range(0, 19);
        m_cy[k] = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 14);
      end
      if (s % 2 == 0) begin
        m_cx[s] = m_px;
        m_cy[s] = m_py;
      end
      run_sweep($sformatf("rand%0d", s), 0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
